// File: rtl/capture_pkg.sv
// capture_pkg: constants shared by the capture/dump block.
// State codes, UART command bytes, hex line separator, nibble-to-ASCII.
package capture_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DUMP    = 2'd3;

    localparam logic [7:0] CMD_ARM   = 8'h61;
    localparam logic [7:0] CMD_FORCE = 8'h66;
    localparam logic [7:0] CMD_ABORT = 8'h78;
    localparam logic [7:0] HEX_SEP   = 8'h0A;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/sample_buf.sv
// sample_buf: DW x DEPTH synchronous FIFO storage, one-cycle read latency.
// Pointers wrap naturally; the array has no reset so it maps to block RAM.
module sample_buf
#(
    parameter int DW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data
);
    import capture_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wr_data;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rptr];
    end

    // Pointers, cleared on reset and on flush
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/capture_dump.sv
// capture_dump: triggered sample capture with UART-paced dump.
// Samples stream out as hex text lines or raw big-endian bytes.
module capture_dump
#(
    parameter int DW    = 8,
    parameter int DEPTH = 256,
    parameter int HEX   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            din,
    input  logic                     din_stb,
    input  logic                     trig,
    input  logic [7:0]               rx_dat,
    input  logic                     rx_stb,
    input  logic                     tx_busy,
    output logic [7:0]               tx_dat,
    output logic                     tx_start,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     done
);
    import capture_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NB = (HEX != 0) ? DW / 4 + 1 : DW / 8;
    localparam int SH = (HEX != 0) ? 4 : 8;

    logic          cmd_arm;
    logic          cmd_force;
    logic          cmd_abort;
    logic          wr_en;
    logic          rd_en;
    logic          buf_clr;
    logic          full_next;
    logic          issue;
    logic          last_byte;
    logic          rd_pend;
    logic          have_word;
    logic [1:0]    gap;
    logic [3:0]    bidx;
    logic [DW-1:0] shreg;
    logic [DW-1:0] rd_data;
    logic [7:0]    byte_nx;

    assign cmd_arm   = rx_stb && (rx_dat == CMD_ARM);
    assign cmd_force = rx_stb && (rx_dat == CMD_FORCE);
    assign cmd_abort = rx_stb && (rx_dat == CMD_ABORT);

    assign wr_en = din_stb && !cmd_abort
                && (count != CW'(DEPTH))
                && ((state == ST_ARMED && trig)
                    || state == ST_CAPTURE);

    assign full_next = (count == CW'(DEPTH - 1));
    assign buf_clr   = cmd_abort || (state == ST_IDLE && cmd_arm);

    // Fetch the next sample only once the previous one is fully sent.
    assign rd_en = (state == ST_DUMP) && !cmd_abort
                && !have_word && !rd_pend
                && (count != '0);

    assign last_byte = (bidx == 4'(NB - 1));

    // gap holds off a new start for two cycles so a late tx_busy is seen.
    assign issue = (state == ST_DUMP) && !cmd_abort && have_word
                && (gap == 2'd0) && !tx_busy;

    sample_buf #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (wr_en),
        .wr_data (din),
        .rd_en   (rd_en),
        .rd_data (rd_data)
    );

    // Next output byte: hex digit / separator, or raw top byte
    always_comb begin
        byte_nx = shreg[DW-1 -: 8];
        if (HEX != 0) begin
            byte_nx = last_byte ? HEX_SEP : hex_char(shreg[DW-1 -: 4]);
        end
    end

    // Control FSM, sample counter and byte serialiser
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            overrun   <= 1'b0;
            done      <= 1'b0;
            tx_start  <= 1'b0;
            tx_dat    <= 8'h00;
            rd_pend   <= 1'b0;
            have_word <= 1'b0;
            gap       <= 2'd2;
            bidx      <= 4'd0;
            shreg     <= '0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            if (gap != 2'd0) gap <= gap - 2'd1;
            if (cmd_abort) begin
                state     <= ST_IDLE;
                count     <= '0;
                rd_pend   <= 1'b0;
                have_word <= 1'b0;
            end else begin
                if (din_stb && state == ST_DUMP) overrun <= 1'b1;
                unique case (state)
                    ST_IDLE: begin
                        if (cmd_arm) begin
                            state   <= ST_ARMED;
                            count   <= '0;
                            overrun <= 1'b0;
                        end else if (cmd_force) begin
                            state <= ST_DUMP;
                        end
                    end
                    ST_ARMED: begin
                        if (wr_en) begin
                            count <= count + 1'b1;
                            state <= (cmd_force || full_next)
                                   ? ST_DUMP : ST_CAPTURE;
                        end else if (cmd_force) begin
                            state <= ST_DUMP;
                        end
                    end
                    ST_CAPTURE: begin
                        if (wr_en) count <= count + 1'b1;
                        if ((wr_en && full_next) || cmd_force)
                            state <= ST_DUMP;
                    end
                    default: begin
                        if (rd_en) rd_pend <= 1'b1;
                        if (rd_pend) begin
                            shreg     <= rd_data;
                            have_word <= 1'b1;
                            rd_pend   <= 1'b0;
                            bidx      <= 4'd0;
                        end
                        if (issue) begin
                            tx_start <= 1'b1;
                            tx_dat   <= byte_nx;
                            gap      <= 2'd2;
                            shreg    <= shreg << SH;
                            bidx     <= bidx + 4'd1;
                            if (last_byte) begin
                                have_word <= 1'b0;
                                count     <= count - 1'b1;
                            end
                        end
                        if (!have_word && !rd_pend && count == '0) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/capture_dump.md
CAPTURE_DUMP -- requirements
Module: capture_dump

Interface
REQ-001 SHALL have parameter DW, default 8, sample width in bits, multiple of 8, range 8..32.
REQ-002 SHALL have parameter DEPTH, default 256, capture depth in samples, power of two, 2..4096.
REQ-003 SHALL have parameter HEX, default 1, dump mode: 1 = ASCII hex with 0x0A after each sample, 0 = raw bytes.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low.
REQ-006 din  in  DW  sample data, valid when din_stb=1.
REQ-007 din_stb  in  1  one-cycle sample strobe.
REQ-008 trig  in  1  trigger qualifier, sampled with din_stb.
REQ-009 rx_dat  in  8  command byte from UART receiver, valid when rx_stb=1.
REQ-010 rx_stb  in  1  one-cycle command strobe.
REQ-011 tx_busy  in  1  UART transmitter busy.
REQ-012 tx_dat  out  8  byte to transmit, stable from tx_start until tx_busy falls.
REQ-013 tx_start  out  1  one-cycle transmit request.
REQ-014 state  out  2  current state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DUMP.
REQ-015 count  out  $clog2(DEPTH)+1  samples held in buffer.
REQ-016 overrun  out  1  sticky: din_stb arrived while in DUMP.
REQ-017 done  out  1  one-cycle pulse when DUMP completes.

Function
REQ-018 SHALL decode commands on rx_stb: 0x61 'a' arm, 0x66 'f' force dump, 0x78 'x' abort; all other bytes ignored.
REQ-019 IDLE: 'a' -> ARMED, clearing count, buffer pointers and overrun; 'f' -> DUMP.
REQ-020 ARMED: din_stb with trig=1 -> CAPTURE, and that sample is the first one stored; din_stb with trig=0 is discarded; 'a' has no effect; 'f' -> DUMP.
REQ-021 CAPTURE: each din_stb stores din and increments count; on the write making count=DEPTH -> DUMP the next cycle; 'f' -> DUMP with the current count.
REQ-022 DUMP: samples SHALL be read out oldest first; din_stb ignored and sets overrun; 'a' and 'f' ignored.
REQ-023 HEX=1: each sample SHALL emit DW/4 characters, most significant nibble first, nibble 0-9 -> 0x30-0x39 and 10-15 -> 0x41-0x46, followed by 0x0A.
REQ-024 HEX=0: each sample SHALL emit DW/8 bytes, most significant byte first, no separator.
REQ-025 tx_start SHALL assert only when tx_busy=0 and a byte is pending.
REQ-026 tx_start SHALL never assert in the two cycles following a tx_start, which tolerates a one-cycle tx_busy lag.
REQ-027 Each sample's count decrement SHALL occur on the tx_start of its final byte.
REQ-028 After the final byte's tx_start: -> IDLE and done=1 for one cycle.
REQ-029 DUMP entered with count=0 SHALL emit no bytes, pulse done one cycle later and return to IDLE.
REQ-030 'x' in any state SHALL go to IDLE next cycle, flush the buffer (count=0) and suppress tx_start in that cycle; it SHALL NOT pulse done.
REQ-031 Priority in one cycle: abort > sample write > command > dump read.
REQ-032 Buffer pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.

Reset
REQ-033 rst=0 at a clock edge SHALL force state=IDLE, count=0, overrun=0, done=0, tx_start=0, tx_dat=0x00 and clear pointers, including mid-dump; the buffer contents are don't-care.
REQ-034 No tx_start SHALL assert in the first cycle after rst returns to 1.

Structure
REQ-035 State encodings, command byte constants and the 0x0A separator SHALL live in a shared package capture_pkg.
REQ-036 Sample storage SHALL be a sub-module sample_buf: a synchronous FIFO DW x DEPTH with one-cycle read latency, inferable as block RAM.
REQ-037 Byte serialisation and hex encoding SHALL live in capture_dump; no UART instance inside.

Verification
REQ-038 DW=8, HEX=1: 'a', then din=0x3C with trig=1, then 0xA5; 'f' -> bytes 0x33 0x43 0x0A 0x41 0x35 0x0A, then done, state=0.
REQ-039 DW=16, HEX=0, DEPTH=4: arm, then 4 triggered samples 0x1234..0x1237 -> automatic DUMP, bytes 12 34 12 35 12 36 12 37, count reaches 0.
REQ-040 tx_busy held 1 for 50 cycles during DUMP -> no tx_start; after release exactly one pending byte sent per busy-free window, never two tx_start pulses within 3 cycles.
REQ-041 'x' sent after 2 bytes of a 6-byte dump -> next cycle state=0, count=0, no further tx_start, done stays 0.
REQ-042 din_stb during DUMP -> overrun=1, dumped data unchanged; next 'a' clears overrun.
REQ-043 'f' in IDLE with empty buffer -> zero tx_start pulses, done pulse, state=0; rst=0 mid-dump -> all outputs at reset values next cycle.
